// File: rtl/store_result_sink.sv
// store_result_sink: data-memory responder that backs a word RAM, judges the
// program's stores as pass/fail, logs every store and enforces a cycle timeout.
module store_result_sink #(
  parameter int DEPTH        = 64,
  parameter int PASS_ADDR    = 100,
  parameter int PASS_DATA    = 25,
  parameter int SCRATCH_ADDR = 96,
  parameter int LOG_DEPTH    = 8,
  parameter int TIMEOUT      = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LOG_DEPTH);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  localparam logic [1:0] S_RUN = 2'd0, S_PASS = 2'd1, S_FAIL = 2'd2;
  logic [31:0] ram [DEPTH];
  logic [31:0] fifo_a [LOG_DEPTH];
  logic [31:0] fifo_d [LOG_DEPTH];
  logic [1:0] state_q, state_d;
  logic [31:0] cnt_q, cnt_d, last_a_q, last_a_d, last_d_q, last_d_d;
  logic timeout_q, timeout_d, ovf_q, ovf_d;
  logic [LW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW:0] occ_q, occ_d;
  logic in_range, run, verdict, to_hit, good, full, pop, push_req, push;
  logic [AW-1:0] idx;
  always_comb begin
    in_range = DataAdr < 32'(4 * DEPTH);
    idx = DataAdr[AW+1:2];
    ReadData = in_range ? ram[idx] : '0;
    run = state_q == S_RUN;
    verdict = MemWrite && DataAdr != 32'(SCRATCH_ADDR);
    good = DataAdr == 32'(PASS_ADDR) && WriteData == 32'(PASS_DATA);
    // a verdicting store in the last allowed cycle wins over the timeout
    to_hit = TIMEOUT != 0 && cnt_q == TO_LAST && !verdict;
    state_d = !run ? state_q : (verdict && good) ? S_PASS : (verdict || to_hit) ? S_FAIL : S_RUN;
    timeout_d = timeout_q | (run && to_hit);
    cnt_d = (run && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    log_valid = occ_q != '0;
    full = occ_q == (LW+1)'(LOG_DEPTH);
    pop = log_valid && log_ready;
    push_req = run && MemWrite;
    push = push_req && (!full || pop);
    ovf_d = ovf_q | (push_req && full && !pop);
    wr_d = push ? wr_q + LW'(1) : wr_q;
    rd_d = pop ? rd_q + LW'(1) : rd_q;
    occ_d = occ_q + (LW+1)'(push) - (LW+1)'(pop);
    last_a_d = pop ? fifo_a[rd_q] : last_a_q;
    last_d_d = pop ? fifo_d[rd_q] : last_d_q;
    log_addr = log_valid ? fifo_a[rd_q] : last_a_q;
    log_data = log_valid ? fifo_d[rd_q] : last_d_q;
    done = state_q != S_RUN;
    pass = state_q == S_PASS;
    fail = state_q == S_FAIL;
    timeout = timeout_q;
    log_overflow = ovf_q;
  end
  always_ff @(posedge clk) begin
    if (MemWrite && in_range) ram[idx] <= WriteData;
    if (push) begin
      fifo_a[wr_q] <= DataAdr;
      fifo_d[wr_q] <= WriteData;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q <= '0;
      timeout_q <= 1'b0;
      ovf_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
      last_a_q <= '0;
      last_d_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
      ovf_q <= ovf_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
      last_a_q <= last_a_d;
      last_d_q <= last_d_d;
    end
  end
endmodule

// File: doc/store_result_sink.md
Name: store_result_sink

Overview:
- Synthesizable responder on the single-cycle core's data-memory store interface (MemWrite, DataAdr, WriteData).
- Backs a small word RAM and supplies ReadData to the core.
- Judges the program's stores against the team's pass/fail convention: a store of 25 to address 100 passes; any store to an address other than 96 fails.
- Logs every store in a FIFO for a host/bench, and enforces a cycle-count timeout.
- Replaces ad-hoc bench checking so the verdict is available on FPGA.

Parameters:
- DEPTH, 64, RAM words (power of 2); RAM spans byte addresses 0..4*DEPTH-1
- PASS_ADDR, 100, byte address of the result store
- PASS_DATA, 25, value at PASS_ADDR that means pass
- SCRATCH_ADDR, 96, the only other byte address where a store is legal
- LOG_DEPTH, 8, store-log FIFO entries (power of 2, ≥2)
- TIMEOUT, 1000, cycles in RUN before forced fail (0 disables the timeout)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- MemWrite  in  1  store strobe from core
- DataAdr  in  32  byte address from core
- WriteData  in  32  store data from core
- ReadData  out  32  load data to core (combinational)
- done  out  1  verdict reached
- pass  out  1  verdict = pass
- fail  out  1  verdict = fail
- timeout  out  1  fail caused by TIMEOUT
- log_valid  out  1  FIFO head valid
- log_ready  in  1  consumer pops head when log_valid & log_ready
- log_addr  out  32  head entry address
- log_data  out  32  head entry data
- log_overflow  out  1  sticky: a store was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, async):
  - State→RUN; done, pass, fail, timeout, log_overflow = 0.
  - FIFO emptied (log_valid=0, log_addr=log_data=0); cycle counter = 0.
  - RAM contents are not reset.
  - Reset mid-run discards the verdict and the log; RAM keeps its contents.
- RAM:
  - Write at rising edge when MemWrite=1 and DataAdr < 4*DEPTH; index DataAdr[log2(DEPTH)+1:2]. DataAdr[1:0] is ignored.
  - Stores outside the RAM range write nothing.
  - ReadData is a combinational read of the same index; returns 0 when out of range.
  - A same-cycle read of the address being written returns the old word.
  - RAM writes occur in every state.
- FSM states: RUN, PASS, FAIL. PASS and FAIL are sticky until reset.
  - RUN, MemWrite=1, DataAdr==PASS_ADDR, WriteData==PASS_DATA → PASS.
  - RUN, MemWrite=1, DataAdr==PASS_ADDR, any other data → FAIL.
  - RUN, MemWrite=1, DataAdr≠PASS_ADDR and ≠SCRATCH_ADDR → FAIL. Full 32-bit compare, so misaligned addresses fail.
  - RUN, store to SCRATCH_ADDR → stay in RUN.
  - RUN, TIMEOUT≠0 and counter reaches TIMEOUT-1 with no verdicting store that cycle → FAIL, timeout=1. A verdicting store in that same cycle takes priority and timeout stays 0.
  - Outputs are registered: done/pass/fail/timeout are valid in the cycle after the deciding edge. done = pass|fail; pass and fail are mutually exclusive.
- Counter:
  - Increments every cycle in RUN; frozen in PASS/FAIL.
  - Saturates; never wraps.
- Log FIFO:
  - Push {DataAdr, WriteData} on each MemWrite while in RUN, including the deciding store. No pushes in PASS/FAIL.
  - First-word fall-through: log_addr/log_data show the head whenever log_valid=1, and hold the last popped value otherwise.
  - Pop when log_valid & log_ready.
  - When full, a push with a simultaneous pop is accepted (occupancy unchanged). A push without a pop is dropped and sets log_overflow (sticky).
  - Pop on empty has no effect. Pointers wrap modulo LOG_DEPTH.

Test Plan:
- Reset release, then stores (96,7) then (100,25) → RAM[24]=7, RAM[25]=25; cycle after the second store: done=1, pass=1, fail=0; log yields (96,7), (100,25).
- Store (100,24) → fail=1, pass=0, timeout=0; a later (100,25) does not change the verdict but still writes RAM[25]=25.
- Store (60,5) → fail=1; ReadData at address 60 returns 5 in the following cycle.
- TIMEOUT=20 with only loads issued → fail=1 and timeout=1 exactly 20 cycles after reset release; counter frozen afterwards.
- LOG_DEPTH=8, log_ready=0, 9 stores to 96 → log_valid=1, log_overflow=1, 8 entries retained. Repeat with log_ready=1 on the 9th store → no overflow.
- Assert reset=0 asynchronously mid-cycle while in PASS → done, pass and log_valid drop immediately; RAM[25] still reads 25 after release.
